// File: rtl/dmi_reg_arbiter.sv
// Two-host arbiter for the core debug register bus: one pending slot per host,
// round-robin grant, ack timeout with error return, and a sticky overrun flag.
module dmi_reg_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        core_clk,
  input  logic        core_rst,

  input  logic        m0_en,
  input  logic        m0_wr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_busy,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  output logic        m0_ovr,
  input  logic        m0_ovr_clr,

  input  logic        m1_en,
  input  logic        m1_wr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_busy,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic        m1_ovr,
  input  logic        m1_ovr_clr,

  output logic        reg_en,
  output logic        reg_wr_en,
  output logic [31:0] reg_wr_addr,
  output logic [31:0] reg_wr_data,
  input  logic [31:0] rd_data,
  input  logic        reg_ack
);

  // Handshake: a host pulses mN_en for one cycle; the block answers with exactly
  // one mN_ack pulse per accepted request. Toward the core, reg_en is a one-cycle
  // pulse and the request fields stay stable until reg_ack (or timeout) ends it.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam bit TO_EN = (TIMEOUT > 0);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [1:0]       req_en, req_wr, ovr_clr;
  logic [1:0][31:0] req_addr, req_wdata;

  logic [1:0]       busy_q, slot_wr_q, ack_q, err_q, ovr_q;
  logic [1:0][31:0] slot_addr_q, slot_wdata_q, rdata_q;
  logic             last_q, gnt_q, gnt_d;
  logic             grant_go, done, done_err, timed_out;
  logic [1:0]       free;
  logic [CW-1:0]    cnt_q;
  logic             reg_en_q, reg_wr_en_q;
  logic [31:0]      reg_wr_addr_q, reg_wr_data_q;

  assign req_en    = {m1_en, m0_en};
  assign req_wr    = {m1_wr, m0_wr};
  assign req_addr  = {m1_addr, m0_addr};
  assign req_wdata = {m1_wdata, m0_wdata};
  assign ovr_clr   = {m1_ovr_clr, m0_ovr_clr};

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    grant_go  = 1'b0;
    done      = 1'b0;
    done_err  = 1'b0;
    timed_out = TO_EN && (cnt_q == CNT_LIMIT);
    case (state_q)
      ST_IDLE: begin
        if (|busy_q) begin
          grant_go = 1'b1;
          state_d  = ST_WAIT;
          // With both slots full the port that did not win last time goes next.
          gnt_d    = (&busy_q) ? ~last_q : busy_q[1];
        end
      end
      ST_WAIT: begin
        if (reg_ack) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end else if (timed_out) begin
          done     = 1'b1;
          done_err = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    free = 2'b00;
    if (done) free[gnt_q] = 1'b1;
  end

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      state_q       <= ST_IDLE;
      busy_q        <= 2'b00;
      slot_wr_q     <= 2'b00;
      slot_addr_q   <= '0;
      slot_wdata_q  <= '0;
      rdata_q       <= '0;
      ack_q         <= 2'b00;
      err_q         <= 2'b00;
      ovr_q         <= 2'b00;
      last_q        <= 1'b1;
      gnt_q         <= 1'b0;
      cnt_q         <= '0;
      reg_en_q      <= 1'b0;
      reg_wr_en_q   <= 1'b0;
      reg_wr_addr_q <= 32'h0;
      reg_wr_data_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      reg_en_q <= grant_go;
      ack_q    <= free;
      err_q    <= done_err ? free : 2'b00;

      if (grant_go) begin
        gnt_q         <= gnt_d;
        reg_wr_en_q   <= slot_wr_q[gnt_d];
        reg_wr_addr_q <= slot_addr_q[gnt_d];
        reg_wr_data_q <= slot_wdata_q[gnt_d];
        cnt_q         <= '0;
      end else if (state_q == ST_WAIT && cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + 1'b1;
      end

      if (done) begin
        last_q <= gnt_q;
        if (!slot_wr_q[gnt_q]) rdata_q[gnt_q] <= done_err ? 32'h0 : rd_data;
      end

      for (int i = 0; i < 2; i++) begin
        // A slot being freed this edge may be refilled on the same edge.
        if (req_en[i] && (!busy_q[i] || free[i])) begin
          busy_q[i]       <= 1'b1;
          slot_wr_q[i]    <= req_wr[i];
          slot_addr_q[i]  <= req_addr[i];
          slot_wdata_q[i] <= req_wdata[i];
        end else if (free[i]) begin
          busy_q[i] <= 1'b0;
        end
        if (req_en[i] && busy_q[i] && !free[i]) ovr_q[i] <= 1'b1;
        else if (ovr_clr[i])                    ovr_q[i] <= 1'b0;
      end
    end
  end

  assign m0_busy     = busy_q[0];
  assign m0_ack      = ack_q[0];
  assign m0_err      = err_q[0];
  assign m0_rdata    = rdata_q[0];
  assign m0_ovr      = ovr_q[0];
  assign m1_busy     = busy_q[1];
  assign m1_ack      = ack_q[1];
  assign m1_err      = err_q[1];
  assign m1_rdata    = rdata_q[1];
  assign m1_ovr      = ovr_q[1];
  assign reg_en      = reg_en_q;
  assign reg_wr_en   = reg_wr_en_q;
  assign reg_wr_addr = reg_wr_addr_q;
  assign reg_wr_data = reg_wr_data_q;

endmodule
